// File: rtl/aes_cipher_serializer_if.sv
// Stream bundle between the AES encrypt wrapper, the cipher serializer and its consumer.
// The slave modport is the serializer's view. The master modport is the view of whatever
// drives the serializer.
interface aes_cipher_serializer_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DEPTH  = 2
);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic              valid_in;
    logic [DATA_W-1:0] cipher_in;
    logic              out_ready;
    logic              out_valid;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic [LVL_W-1:0]  level;
    logic              overflow;

    modport master (
        output valid_in,
        output cipher_in,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  level,
        input  overflow
    );

    modport slave (
        input  valid_in,
        input  cipher_in,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_last,
        output level,
        output overflow
    );
endinterface

// File: rtl/aes_cipher_serializer.sv
// Buffers up to DEPTH cipher blocks and emits each one MSW-first as WORD_W-bit words over a
// valid/ready stream. Blocks that arrive while the buffer is full are dropped. A sticky flag
// records that a drop has happened.
module aes_cipher_serializer #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    aes_cipher_serializer_if.slave bus
);
    localparam int unsigned WORDS = DATA_W / WORD_W;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              overflow_q, overflow_d;

    logic              valid;
    logic              xfer;
    logic              last_xfer;
    logic              space;
    logic              wr_en;
    logic              drop;
    logic [DATA_W-1:0] head;
    logic [WORD_W-1:0] head_words [WORDS];

    function automatic logic [PTR_W-1:0] ptr_adv(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Split the head block into words, index 0 being the most significant.
    assign head = mem[rd_ptr_q];
    for (genvar g = 0; g < WORDS; g++) begin : g_words
        assign head_words[g] = head[DATA_W-1-g*WORD_W -: WORD_W];
    end

    // Handshake decode and next-state. The last word leaving frees a slot on the same edge.
    always_comb begin
        valid      = (level_q != '0);
        xfer       = valid && bus.out_ready;
        last_xfer  = xfer && (idx_q == LAST_IDX);
        space      = (level_q < FULL_LVL) || last_xfer;
        wr_en      = bus.valid_in && space;
        drop       = bus.valid_in && !space;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        idx_d      = idx_q;
        level_d    = level_q;
        overflow_d = overflow_q | drop;

        if (wr_en) begin
            wr_ptr_d = ptr_adv(wr_ptr_q);
        end
        if (last_xfer) begin
            rd_ptr_d = ptr_adv(rd_ptr_q);
            idx_d    = '0;
        end else if (xfer) begin
            idx_d = idx_q + IDX_W'(1);
        end

        unique case ({wr_en, last_xfer})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            idx_q      <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            idx_q      <= idx_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Block storage has no reset. Writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[wr_ptr_q] <= cipher_in_sel();
        end
    end

    function automatic logic [DATA_W-1:0] cipher_in_sel();
        return bus.cipher_in;
    endfunction

    // Outputs come from registers only. Data is forced to zero when nothing is held, so reset
    // never exposes stale storage.
    assign bus.out_valid = valid;
    assign bus.out_data  = valid ? head_words[idx_q] : '0;
    assign bus.out_last  = valid && (idx_q == LAST_IDX);
    assign bus.level     = level_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_aes_cipher_serializer.sv
// Directed bench for aes_cipher_serializer. The design is exercised with single blocks,
// back-pressure, overflow, full-with-drain, reset mid-block and continuous input.
module tb_aes_cipher_serializer;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned DEPTH  = 2;

    localparam logic [127:0] B0 = 128'h00112233_44556677_8899aabb_ccddeeff;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int unsigned cyc;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    xfer_t       got_q[$];

    aes_cipher_serializer_if #(.DATA_W(DATA_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) bus ();

    aes_cipher_serializer #(
        .DATA_W(DATA_W),
        .WORD_W(WORD_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every word that will transfer on the coming rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            got_q.push_back('{bus.out_data, bus.out_last, cyc});
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk_blk(input int i);
        logic [31:0] b;
        b = 32'hC0DE0000 | (32'(i) << 8);
        return {b, b | 32'd1, b | 32'd2, b | 32'd3};
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] blk, input int w);
        return 32'(blk >> (32 * (3 - w)));
    endfunction

    // Compare four recorded transfers starting at base with the words of blk.
    task automatic expect_block(input int base, input logic [127:0] blk, input string tag);
        for (int w = 0; w < 4; w++) begin
            if (base + w < got_q.size()) begin
                check_eq({tag, "_data"}, 128'(got_q[base+w].data), 128'(word_of(blk, w)));
                check_eq({tag, "_last"}, 128'(got_q[base+w].last), 128'(w == 3));
            end else begin
                check_eq({tag, "_missing"}, 128'(got_q.size()), 128'(base + w + 1));
            end
        end
    endtask

    task automatic pulse(input logic [127:0] blk);
        bus.valid_in  = 1'b1;
        bus.cipher_in = blk;
        tick(1);
        bus.valid_in  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bp_pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        int sent;
        int gaps;

        bus.valid_in  = 1'b0;
        bus.cipher_in = '0;
        bus.out_ready = 1'b0;
        tick(2);

        // Reset state
        check_eq("rst_valid", 128'(bus.out_valid), 128'd0);
        check_eq("rst_last", 128'(bus.out_last), 128'd0);
        check_eq("rst_data", 128'(bus.out_data), 128'd0);
        check_eq("rst_level", 128'(bus.level), 128'd0);
        check_eq("rst_ovf", 128'(bus.overflow), 128'd0);
        rst_n = 1'b1;
        tick(1);

        // Single block, ready held high
        got_q.delete();
        bus.out_ready = 1'b1;
        pulse(B0);
        check_eq("single_level1", 128'(bus.level), 128'd1);
        check_eq("single_valid", 128'(bus.out_valid), 128'd1);
        check_eq("single_first", 128'(bus.out_data), 128'h00112233);
        tick(4);
        check_eq("single_level0", 128'(bus.level), 128'd0);
        check_eq("single_ovf", 128'(bus.overflow), 128'd0);
        check_eq("single_count", 128'(got_q.size()), 128'd4);
        expect_block(0, B0, "single");
        if (got_q.size() == 4) begin
            check_eq("single_span", 128'(got_q[3].cyc - got_q[0].cyc), 128'd3);
        end

        // Back-pressure
        got_q.delete();
        bus.out_ready = 1'b0;
        pulse(B0);
        sent = 0;
        for (int k = 0; k < 7; k++) begin
            check_eq("bp_word", 128'(bus.out_data), 128'(word_of(B0, sent)));
            check_eq("bp_last", 128'(bus.out_last), 128'(sent == 3));
            bus.out_ready = (bp_pat[k] != 0);
            tick(1);
            if (bp_pat[k] != 0) sent++;
        end
        bus.out_ready = 1'b0;
        check_eq("bp_count", 128'(got_q.size()), 128'd4);
        check_eq("bp_level0", 128'(bus.level), 128'd0);
        expect_block(0, B0, "bp");

        // Overflow: three blocks into a two-deep buffer while stalled
        got_q.delete();
        for (int i = 1; i <= 3; i++) pulse(mk_blk(i));
        check_eq("ovf_level", 128'(bus.level), 128'd2);
        check_eq("ovf_flag", 128'(bus.overflow), 128'd1);
        bus.out_ready = 1'b1;
        tick(10);
        bus.out_ready = 1'b0;
        check_eq("ovf_count", 128'(got_q.size()), 128'd8);
        expect_block(0, mk_blk(1), "ovf_a");
        expect_block(4, mk_blk(2), "ovf_b");
        check_eq("ovf_sticky", 128'(bus.overflow), 128'd1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check_eq("ovf_cleared", 128'(bus.overflow), 128'd0);

        // Full buffer accepting a block on the head's last-word edge
        got_q.delete();
        pulse(mk_blk(4));
        pulse(mk_blk(5));
        check_eq("fd_level_full", 128'(bus.level), 128'd2);
        bus.out_ready = 1'b1;
        tick(3);
        check_eq("fd_at_last", 128'(bus.out_last), 128'd1);
        pulse(mk_blk(6));
        check_eq("fd_level_kept", 128'(bus.level), 128'd2);
        check_eq("fd_no_ovf", 128'(bus.overflow), 128'd0);
        check_eq("fd_next_head", 128'(bus.out_data), 128'(word_of(mk_blk(5), 0)));
        tick(8);
        bus.out_ready = 1'b0;
        check_eq("fd_count", 128'(got_q.size()), 128'd12);
        expect_block(0, mk_blk(4), "fd_e");
        expect_block(4, mk_blk(5), "fd_f");
        expect_block(8, mk_blk(6), "fd_d");
        check_eq("fd_level0", 128'(bus.level), 128'd0);

        // Reset after two words of a block
        got_q.delete();
        bus.out_ready = 1'b1;
        pulse(mk_blk(7));
        tick(2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check_eq("mr_valid", 128'(bus.out_valid), 128'd0);
        check_eq("mr_level", 128'(bus.level), 128'd0);
        check_eq("mr_ovf", 128'(bus.overflow), 128'd0);
        pulse(mk_blk(8));
        tick(4);
        check_eq("mr_count", 128'(got_q.size()), 128'd6);
        if (got_q.size() >= 2) begin
            check_eq("mr_g0", 128'(got_q[0].data), 128'(word_of(mk_blk(7), 0)));
            check_eq("mr_g1", 128'(got_q[1].data), 128'(word_of(mk_blk(7), 1)));
        end
        expect_block(2, mk_blk(8), "mr_h");

        // Continuous input: blocks 0, 1 and 4 of the burst are the ones that fit
        got_q.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.valid_in  = 1'b1;
            bus.cipher_in = mk_blk(16 + i);
            tick(1);
        end
        bus.valid_in = 1'b0;
        tick(12);
        bus.out_ready = 1'b0;
        check_eq("ci_count", 128'(got_q.size()), 128'd12);
        expect_block(0, mk_blk(16), "ci_k0");
        expect_block(4, mk_blk(17), "ci_k1");
        expect_block(8, mk_blk(20), "ci_k4");
        gaps = 0;
        for (int k = 1; k < got_q.size(); k++) begin
            if (got_q[k].cyc != got_q[k-1].cyc + 1) gaps++;
        end
        check_eq("ci_no_bubble", 128'(gaps), 128'd0);
        check_eq("ci_ovf", 128'(bus.overflow), 128'd1);
        check_eq("ci_level0", 128'(bus.level), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_cipher_serializer.md
Name: aes_cipher_serializer

Overview:
Downstream stage of the AES encrypt wrapper. It captures each registered 128-bit cipher_text_128 on its valid_out pulse and buffers up to DEPTH blocks. It emits each block as WORD_W-bit words over a valid/ready stream, most-significant word first, with out_last marking the final word. It adds the back-pressure tolerance the encrypt stage lacks, and flags any block dropped because the buffer is full.

Parameters:
DATA_W, 128, cipher block width; must be a multiple of WORD_W.
WORD_W, 32, output word width; WORDS = DATA_W/WORD_W (4 by default).
DEPTH, 2, buffered block capacity; must be a power of two and at least 1.

Ports:
clk  input  1  single clock; all logic on the rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
valid_in  input  1  one-cycle strobe: cipher_in holds a new block (driven by the encrypt wrapper's valid_out).
cipher_in  input  DATA_W  cipher block (the encrypt wrapper's cipher_text_128).
out_ready  input  1  downstream accepts out_data this cycle.
out_valid  output  1  out_data holds a valid word.
out_data  output  WORD_W  current word of the head block.
out_last  output  1  high with out_valid on the last word of a block.
level  output  clog2(DEPTH+1)  number of blocks currently held, including any partly sent block.
overflow  output  1  sticky: at least one block was dropped since reset.

Behaviour:
- Reset: synchronous, active-low. On a clk edge with rst_n=0:
  - out_valid=0, out_last=0, out_data=0, level=0, overflow=0.
  - Word index, write pointer and read pointer cleared to 0.
  - Buffer contents need not be cleared.
  - valid_in is ignored in the reset cycle.
- Storage: DEPTH x DATA_W register array, with wr_ptr, rd_ptr, a level counter and a word index (0..WORDS-1) into the head block.
- Write: on an edge with valid_in=1 and space available, store cipher_in at wr_ptr. wr_ptr advances modulo DEPTH.
  - Space available means level<DEPTH, OR level==DEPTH with the last word of the head block transferring on the same edge.
- Output:
  - out_valid = (level!=0).
  - out_data = slice (DATA_W-1-idx*WORD_W) down to (DATA_W-WORD_W-idx*WORD_W) of the head block, so idx 0 gives bits [127:96] by default.
  - out_last = out_valid && idx==WORDS-1.
  - Outputs derive only from registers; there is no combinational path from valid_in/cipher_in to any output.
- Latency: a block captured on edge N gives out_valid=1 from edge N, visible in cycle N+1 when the buffer was empty. With out_ready held at 1, the block drains in WORDS consecutive cycles.
- Transfer: occurs when out_valid && out_ready on an edge.
  - idx increments on each transfer.
  - On the transfer with idx==WORDS-1: idx returns to 0, rd_ptr advances modulo DEPTH, and level decrements.
- Stability: while out_valid=1 and out_ready=0, out_data, out_last and idx are held. A concurrent write never changes them.
- Simultaneous write and last-word transfer: level is unchanged, both pointers advance, and the new block is accepted even when level==DEPTH.
- Full: valid_in with no space available drops the block. Buffer, pointers and level are unchanged, and overflow is set to 1 on that edge. Only reset clears overflow.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble cycle. Back-to-back blocks drain with no idle cycle between the last word of one block and the first word of the next.
- Derived states (no separate state register):
  - EMPTY: level=0.
  - SENDING: 0<level<DEPTH.
  - FULL: level=DEPTH.
  - Transitions follow the write and last-word-transfer rules above.
- Reset mid-operation: discards all blocks, including a partly sent one. The first word after reset is word 0 of the next captured block.

Test Plan:
- Single block: valid_in pulse with cipher_in=0x00112233_44556677_8899aabb_ccddeeff, out_ready=1 -> words 0x00112233, 0x44556677, 0x8899aabb, 0xccddeeff on 4 consecutive cycles; out_last only on 0xccddeeff; level returns 1->0; overflow=0.
- Back-pressure: same block, out_ready toggling 1,0,0,1,1,0,1 -> each word held while ready=0; exactly 4 transfers in MSW-first order; no duplicated or skipped word.
- Overflow: out_ready=0, three valid_in pulses with blocks A, B, C -> level=2, overflow=1; after releasing ready, output is A then B (8 words) and C never appears.
- Full plus simultaneous drain: level=2, head at idx=3 with out_ready=1, valid_in with block D on the same edge -> level stays 2, overflow stays 0; D is emitted after the remaining block.
- Reset mid-block: rst_n=0 for one edge after 2 words of a block -> next cycle out_valid=0, level=0, overflow=0; the next block starts at word 0.
- Continuous input: valid_in every cycle for 8 cycles, out_ready=1 -> no bubbles in the output; overflow=1, because input rate (1 block/cycle) exceeds drain rate (1 block/4 cycles); accepted blocks are emitted in arrival order.
